// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among four execute-unit result
// sources (ALU0, ALU1, LSU, BRU), with the winning result captured into a single
// registered CDB stage that has a valid/ready handshake.
module cdb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic [3:0]          req_valid,
    input  logic [4*DATA_W-1:0] req_data,
    input  logic [4*TAG_W-1:0]  req_tag,
    output logic [3:0]          req_ready,
    output logic                cdb_valid,
    output logic [DATA_W-1:0]   cdb_data,
    output logic [TAG_W-1:0]    cdb_tag,
    output logic [1:0]          cdb_sel,
    input  logic                cdb_ready
);

    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [1:0]        sel_q, sel_d;

    logic              can_load;
    logic              gnt_found;
    logic [1:0]        gnt_idx;
    logic [1:0]        cand;
    logic              gnt_en;
    logic [DATA_W-1:0] win_data;
    logic [TAG_W-1:0]  win_tag;

    // The output stage may take a new beat when empty or being drained this cycle.
    assign can_load = !valid_q || cdb_ready;

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Grant is suppressed during reset, flush and backpressure.
    assign gnt_en    = rst_n && can_load && !flush && gnt_found;
    assign req_ready = gnt_en ? (4'b0001 << gnt_idx) : 4'b0000;

    // Result mux driven by the grant index.
    assign win_data = req_data[gnt_idx*DATA_W +: DATA_W];
    assign win_tag  = req_tag[gnt_idx*TAG_W +: TAG_W];

    // Next-state for the output stage and round-robin pointer; flush dominates.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        valid_d  = valid_q;
        data_d   = data_q;
        tag_d    = tag_q;
        sel_d    = sel_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (can_load) begin
            if (gnt_en) begin
                valid_d  = 1'b1;
                data_d   = win_data;
                tag_d    = win_tag;
                sel_d    = gnt_idx;
                rr_ptr_d = gnt_idx + 2'd1;
            end else begin
                // Payload is kept so the bus does not toggle on idle cycles.
                valid_d = 1'b0;
            end
        end
    end

    // Output stage and pointer registers; reset discards any in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 2'd0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            tag_q    <= '0;
            sel_q    <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            tag_q    <= tag_d;
            sel_q    <= sel_d;
        end
    end

    assign cdb_valid = valid_q;
    assign cdb_data  = data_q;
    assign cdb_tag   = tag_q;
    assign cdb_sel   = sel_q;

    // Grant is one-hot or zero, and only ever to a requester that is asking.
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    a_gnt_valid:  assert property (@(posedge clk) disable iff (!rst_n)
                                   (req_ready & ~req_valid) == 4'b0000);

endmodule
